// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings, slave state type and byte-lane helper
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      SLV_IDLE,
      SLV_WAIT,
      SLV_DATA,
      SLV_ERR1,
      SLV_ERR2
   } slv_state_t;

   // Little-endian lane enables for one transfer
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] m;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << a;
         HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
         default:    m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// rtl/ahb_slv_mem.sv - word array with byte-enable write and asynchronous read
module ahb_slv_mem #(
   parameter int DEPTH  = 256,
   parameter int WIDTH  = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [3:0]       we,
   input  logic [IDX_W-1:0] idx,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with wait states; ERROR path under AHB_SLV_ERR_EN
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    MEM_DEPTH   = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  RESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
`ifdef AHB_SLV_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   slv_state_t            state, state_n;
   logic [3:0]            wait_cnt, wait_n;
   logic [IDX_W-1:0]      cap_idx;
   logic [3:0]            cap_be;
   logic                  cap_write;
   logic                  cap_ok;
   logic                  take;

   logic [ADDR_WIDTH-1:0] offset;
   logic                  accept;
   logic                  size_bad, align_bad, range_bad, addr_bad;
   logic [3:0]            mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  unused_ok;

   assign unused_ok = &{1'b0, HMASTLOCK, HBURST, HTRANS[0]};

   // Bursts are not tracked: every SEQ/NONSEQ beat is decoded on its own
   assign accept    = HSEL & HREADY & HTRANS[1];
   assign offset    = HADDR - BASE_ADDR;
   assign size_bad  = HSIZE > HSIZE_WORD;
   assign align_bad = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
   assign range_bad = {1'b0, offset} >= MEM_BYTES;
   assign addr_bad  = size_bad | align_bad | range_bad;

   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      take    = 1'b0;
      case (state)
         SLV_IDLE, SLV_DATA, SLV_ERR2: begin
            if (accept) begin
               take = 1'b1;
               if (ERR_EN && addr_bad) begin
                  state_n = SLV_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_n = SLV_WAIT;
                  wait_n  = WAIT_LOAD;
               end else begin
                  state_n = SLV_DATA;
               end
            end else begin
               state_n = SLV_IDLE;
            end
         end
         SLV_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_n = SLV_DATA;
            end else begin
               wait_n = wait_cnt - 4'd1;
            end
         end
         SLV_ERR1: state_n = SLV_ERR2;
         default:  state_n = SLV_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge RESET) begin
      if (!RESET) begin
         state     <= SLV_IDLE;
         wait_cnt  <= 4'd0;
         cap_idx   <= '0;
         cap_be    <= 4'b0000;
         cap_write <= 1'b0;
         cap_ok    <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_n;
         if (take) begin
            cap_idx   <= offset[IDX_W+1:2];
            cap_be    <= lane_mask(HSIZE, HADDR[1:0]);
            cap_write <= HWRITE;
            cap_ok    <= ~addr_bad;
         end
      end
   end

   // Writes commit only on the DATA edge, so a reset during WAIT drops them
   assign mem_we = (state == SLV_DATA && cap_write && cap_ok) ? cap_be : 4'b0000;

   ahb_slv_mem #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (DATA_WIDTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk   (HCLK),
      .we    (mem_we),
      .idx   (cap_idx),
      .wdata (HWDATA),
      .rdata (mem_rdata)
   );

   assign HRDATA    = (state == SLV_DATA && !cap_write && cap_ok) ? mem_rdata : '0;
   assign HREADYOUT = !(state == SLV_WAIT || state == SLV_ERR1);
`ifdef AHB_SLV_ERR_EN
   assign HRESP     = (state == SLV_ERR1) || (state == SLV_ERR2);
`else
   assign HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - scoreboard bench for ahb_sram_slave (zero and three wait-state instances)
module tb_ahb_sram_slave;

   logic        HCLK = 1'b0;
   logic        RESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;

   logic        sel;
   logic        hsel0, hsel3;
   logic [31:0] rd0, rd3, rdata_m;
   logic        ro0, ro3, rs0, rs3, rdy_m, resp_m;

   always #5 HCLK = ~HCLK;

   assign hsel0   = HSEL & ~sel;
   assign hsel3   = HSEL & sel;
   assign rdata_m = sel ? rd3 : rd0;
   assign rdy_m   = sel ? ro3 : ro0;
   assign resp_m  = sel ? rs3 : rs0;

   ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
      .HCLK(HCLK), .RESET(RESET), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
      .HREADY(ro0), .HWDATA(HWDATA), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
   );

   ahb_sram_slave #(.WAIT_STATES(3)) dut3 (
      .HCLK(HCLK), .RESET(RESET), .HSEL(hsel3), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
      .HREADY(ro3), .HWDATA(HWDATA), .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3)
   );

`ifdef AHB_SLV_ERR_EN
   localparam logic ERR_RESP  = 1'b1;
   localparam int   ERR_WAITS = 1;
`else
   localparam logic ERR_RESP  = 1'b0;
   localparam int   ERR_WAITS = 0;
`endif

   typedef struct {
      logic        chk_rd;
      logic [31:0] rdata;
      logic        resp;
      int          waits;
      string       nm;
   } exp_t;

   exp_t        expq[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic        ph_valid = 1'b0;
   logic        dp_pend  = 1'b0;
   int          lowcnt   = 0;
   logic        low_resp_bad = 1'b0;
   logic [31:0] pend_wdata = 32'h0;
   int          cur_waits = 0;
   exp_t        e;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Monitor: tracks each accepted address phase through its data phase
   always @(negedge HCLK) begin
      if (!RESET) begin
         dp_pend = 1'b0;
      end else begin
         if (dp_pend) begin
            if (expq.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL scoreboard: data phase with no expectation queued");
               dp_pend = 1'b0;
            end else if (!rdy_m) begin
               lowcnt++;
               if (resp_m !== expq[0].resp) low_resp_bad = 1'b1;
            end else begin
               e = expq.pop_front();
               check({e.nm, "_waits"}, 32'(lowcnt), 32'(e.waits));
               check({e.nm, "_resp"}, {31'b0, resp_m}, {31'b0, e.resp});
               if (lowcnt > 0) check({e.nm, "_lowresp"}, {31'b0, low_resp_bad}, 32'h0);
               if (e.chk_rd) check({e.nm, "_rdata"}, rdata_m, e.rdata);
               dp_pend = 1'b0;
            end
         end
         if (ph_valid && rdy_m) begin
            dp_pend      = 1'b1;
            lowcnt       = 0;
            low_resp_bad = 1'b0;
         end
      end
   end

   task automatic beat(input logic hs, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic crd,
                       input logic [31:0] erd, input logic ersp, input int ew, input string nm);
      int n;
      exp_t x;
      HSEL     = hs;
      HTRANS   = tr;
      HWRITE   = wr;
      HSIZE    = sz;
      HADDR    = a;
      HWDATA   = pend_wdata;
      ph_valid = 1'b1;
      x.chk_rd = crd; x.rdata = erd; x.resp = ersp; x.waits = ew; x.nm = nm;
      expq.push_back(x);
      n = 0;
      @(negedge HCLK);
      while (!rdy_m && n < 64) begin
         n++;
         @(negedge HCLK);
      end
      if (n >= 64) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_accept: HREADYOUT stuck low, required high within 64 cycles", nm);
      end
      @(posedge HCLK);
      #1;
      pend_wdata = wd;
   endtask

   task automatic wr_t(input logic [1:0] tr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input string nm);
      beat(1'b1, tr, 1'b1, sz, a, wd, 1'b0, 32'h0, 1'b0, cur_waits, nm);
   endtask

   task automatic rd_t(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] erd,
                       input string nm);
      beat(1'b1, tr, 1'b0, 3'b010, a, 32'h0, 1'b1, erd, 1'b0, cur_waits, nm);
   endtask

   task automatic flush();
      int n;
      HSEL     = 1'b0;
      HTRANS   = 2'b00;
      HWDATA   = pend_wdata;
      ph_valid = 1'b0;
      n = 0;
      @(negedge HCLK); #1;
      while ((expq.size() != 0 || dp_pend) && n < 64) begin
         n++;
         @(negedge HCLK); #1;
      end
      if (n >= 64) begin
         n_vec++;
         n_bad++;
         $display("FAIL flush: %0d expectations outstanding, required 0", expq.size());
         expq.delete();
      end
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      RESET = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'b010; HBURST = 3'b000; HMASTLOCK = 1'b0; HWDATA = 32'h0; sel = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      check("rst_ready0", {31'b0, ro0}, 32'h1);
      check("rst_resp0",  {31'b0, rs0}, 32'h0);
      check("rst_rdata0", rd0, 32'h0);
      check("rst_ready3", {31'b0, ro3}, 32'h1);
      check("rst_resp3",  {31'b0, rs3}, 32'h0);
      check("rst_rdata3", rd3, 32'h0);
      RESET = 1'b1;
      @(posedge HCLK); #1;

      // zero wait states
      sel = 1'b0; cur_waits = 0;
      wr_t(2'b10, 3'b010, 32'h10, 32'hDEADBEEF, "w10");
      rd_t(2'b10, 32'h10, 32'hDEADBEEF, "r10_b2b");
      wr_t(2'b10, 3'b010, 32'h10, 32'h11223344, "w10b");
      wr_t(2'b10, 3'b000, 32'h13, 32'hA5776655, "wb13");
      rd_t(2'b10, 32'h10, 32'hA5223344, "r_byte");
      wr_t(2'b10, 3'b001, 32'h12, 32'hBEEF9999, "wh12");
      rd_t(2'b10, 32'h10, 32'hBEEF3344, "r_half");
      wr_t(2'b10, 3'b000, 32'h11, 32'h1111C311, "wb11");
      rd_t(2'b10, 32'h10, 32'hBEEFC344, "r_b11");
      beat(1'b1, 2'b00, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 0, "idle");
      beat(1'b1, 2'b01, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 0, "busy");
      beat(1'b0, 2'b10, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 0, "unsel");
      rd_t(2'b10, 32'h10, 32'hBEEFC344, "r_after_idle");
      wr_t(2'b10, 3'b010, 32'h3FC, 32'h0BADCAFE, "wtop");
      rd_t(2'b10, 32'h3FC, 32'h0BADCAFE, "rtop");
      flush();

      // invalid accesses
      beat(1'b1, 2'b10, 1'b0, 3'b010, 32'h02,  32'h0, 1'b1, 32'h0, ERR_RESP, ERR_WAITS, "e_rd02");
      beat(1'b1, 2'b00, 1'b0, 3'b010, 32'h0,   32'h0, 1'b0, 32'h0, 1'b0, 0, "e_gap1");
      beat(1'b1, 2'b10, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0, ERR_RESP, ERR_WAITS, "e_rd400");
      beat(1'b1, 2'b00, 1'b0, 3'b010, 32'h0,   32'h0, 1'b0, 32'h0, 1'b0, 0, "e_gap2");
      beat(1'b1, 2'b10, 1'b1, 3'b010, 32'h12,  32'hFFFFFFFF, 1'b0, 32'h0, ERR_RESP, ERR_WAITS, "e_wr12");
      beat(1'b1, 2'b10, 1'b1, 3'b011, 32'h10,  32'hFFFFFFFF, 1'b0, 32'h0, ERR_RESP, ERR_WAITS, "e_sz3");
      beat(1'b1, 2'b10, 1'b1, 3'b001, 32'h11,  32'hFFFFFFFF, 1'b0, 32'h0, ERR_RESP, ERR_WAITS, "e_half11");
      beat(1'b1, 2'b00, 1'b0, 3'b010, 32'h0,   32'h0, 1'b0, 32'h0, 1'b0, 0, "e_gap3");
      rd_t(2'b10, 32'h10, 32'hBEEFC344, "r_after_err");
      flush();

      // three wait states: INCR burst write/read and a single read
      sel = 1'b1; cur_waits = 3; HBURST = 3'b001;
      wr_t(2'b10, 3'b010, 32'h20, 32'h10000001, "bw20");
      wr_t(2'b11, 3'b010, 32'h24, 32'h20000002, "bw24");
      wr_t(2'b11, 3'b010, 32'h28, 32'h30000003, "bw28");
      wr_t(2'b11, 3'b010, 32'h2C, 32'h40000004, "bw2c");
      rd_t(2'b10, 32'h20, 32'h10000001, "br20");
      rd_t(2'b11, 32'h24, 32'h20000002, "br24");
      rd_t(2'b11, 32'h28, 32'h30000003, "br28");
      rd_t(2'b11, 32'h2C, 32'h40000004, "br2c");
      flush();
      HBURST = 3'b000;
      rd_t(2'b10, 32'h28, 32'h30000003, "r_single");
      wr_t(2'b10, 3'b010, 32'h40, 32'h00000000, "pre40");
      flush();

      // reset during WAIT of a write
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010; HADDR = 32'h40;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hCAFEF00D;
      @(negedge HCLK);
      check("mid_wait_ready", {31'b0, rdy_m}, 32'h0);
      #1 RESET = 1'b0;
      #1;
      check("rst_async_ready", {31'b0, rdy_m}, 32'h1);
      check("rst_async_resp",  {31'b0, resp_m}, 32'h0);
      check("rst_async_rdata", rdata_m, 32'h0);
      @(posedge HCLK); #1;
      RESET = 1'b1;
      @(posedge HCLK); #1;
      pend_wdata = 32'h0;
      rd_t(2'b10, 32'h40, 32'h00000000, "r40_after_rst");
      flush();

      sel = 1'b0; cur_waits = 0;
      rd_t(2'b10, 32'h10, 32'hBEEFC344, "r10_after_rst");
      flush();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_vec++;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
